priority_irq_encoder: RTL and testbench
=======================================

PRIORITY_IRQ_ENCODER -- requirements
Module: priority_irq_encoder

Interface
REQ-001 Parameter N, default 16, number of request channels; legal range 2..64.
REQ-002 Parameter RR_MODE, default 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 Derived localparam W = $clog2(N), index width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N  request lines; a rising edge on req[i] raises an event on channel i.
REQ-007 mask_we  input  1  mask write strobe.
REQ-008 mask_wdata  input  N  new mask value; bit 1 = channel enabled.
REQ-009 out_ready  input  1  consumer accepts the presented index.
REQ-010 out_valid  output  1  out_index holds a granted channel.
REQ-011 out_index  output  W  granted channel number.
REQ-012 any_pending  output  1  at least one enabled channel is pending, excluding the one presented.
REQ-013 mask_q  output  N  current mask register.

Function
REQ-014 req shall be registered into req_q every cycle; an event on channel i is req[i] & ~req_q[i] at a clock edge.
REQ-015 An event shall set pending[i] at the same edge; pending is sticky until granted.
REQ-016 On mask_we, mask_q shall load mask_wdata at the edge; masking shall not clear pending bits, and masked pending bits become eligible again when unmasked.
REQ-017 Eligible vector E = pending & mask_q, taken from registered values only; any_pending = |E (combinational from registers).
REQ-018 Load condition L = ~out_valid | (out_valid & out_ready).
REQ-019 When L and E != 0, at the edge: out_valid = 1, out_index = selected channel s, pending[s] cleared.
REQ-020 When L and E == 0, out_valid shall go 0 at the edge; out_index shall hold its last value.
REQ-021 When out_valid & ~out_ready, out_valid and out_index shall hold stable; no change to mask or pending shall alter them.
REQ-022 A back-to-back handshake (out_ready held high) shall present one new grant per cycle while E != 0.
REQ-023 If an event on channel s occurs at the edge where pending[s] is cleared by a grant, set shall win and pending[s] stays 1.
REQ-024 RR_MODE=0: s = highest index set in E.
REQ-025 RR_MODE=1: a pointer ptr (W bits) shall be kept; s = first set bit in E searching downward from ptr with wrap from 0 to N-1; on each grant ptr = (s == 0) ? N-1 : s-1.
REQ-026 Two states: IDLE (out_valid=0) and PRESENT (out_valid=1); IDLE->PRESENT when E != 0; PRESENT->PRESENT on handshake with E != 0 or no handshake; PRESENT->IDLE on handshake with E == 0.
REQ-027 Latency: req first sampled high at edge t (low at t-1) -> pending at t -> out_valid at t+1 if the output is loadable and the channel wins.

Reset
REQ-028 On rst high, immediately and independently of clk: req_q=0, pending=0, mask_q=all ones, ptr=N-1, out_valid=0, out_index=0; any_pending therefore 0.
REQ-029 Reset asserted mid-handshake shall discard the presented grant and all pending events without any further output.
REQ-030 A req bit held high through reset deassertion shall register as one event at the first edge after reset.

Verification (N=8)
REQ-031 RR_MODE=0, pulse req=8'b0010_0100 at once, out_ready=1 -> out_index 5 then 2 on consecutive cycles, then out_valid=0.
REQ-032 RR_MODE=0, out_ready=0, event ch3 then ch7 -> out_index stays 3 until out_ready, then 7.
REQ-033 RR_MODE=1, req[7], req[6], and req[1] held high with a new event each grant, out_ready=1 -> grants rotate 7,6,1,7,6,1.
REQ-034 mask_wdata=8'h00 written, event ch4 -> out_valid stays 0 and any_pending=0; mask=8'hFF -> ch4 granted next cycle.
REQ-035 Event ch2 at the same edge as ch2 handshake/grant clear -> ch2 granted again afterwards.
REQ-036 rst pulsed while out_valid=1 with 3 pending -> all outputs at reset values at once, no grants after release.

Source files
------------

// File: rtl/priority_irq_encoder_if.sv
// ----------------------------------------------------------------------------
// priority_irq_encoder_if
// Bundles the request/mask/grant signals of priority_irq_encoder.
//   req         : N-bit request lines, an edge on req[i] raises an event
//   mask_we     : mask write strobe
//   mask_wdata  : N-bit mask value, 1 = channel enabled
//   out_ready   : consumer accepts the presented index
//   out_valid   : out_index holds a granted channel
//   out_index   : W-bit granted channel number
//   any_pending : an enabled channel is still pending besides the presented one
//   mask_q      : current mask register
// master = request source / grant consumer, slave = the encoder.
// ----------------------------------------------------------------------------
interface priority_irq_encoder_if #(
   parameter int N = 16
);
   localparam int W = $clog2(N);

   logic [N-1:0] req;
   logic         mask_we;
   logic [N-1:0] mask_wdata;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_index;
   logic         any_pending;
   logic [N-1:0] mask_q;

   modport master (
      output req, mask_we, mask_wdata, out_ready,
      input  out_valid, out_index, any_pending, mask_q
   );

   modport slave (
      input  req, mask_we, mask_wdata, out_ready,
      output out_valid, out_index, any_pending, mask_q
   );
endinterface

// File: rtl/priority_irq_encoder.sv
// ----------------------------------------------------------------------------
// priority_irq_encoder
// Edge-detects N request lines into sticky pending bits, masks them, and
// presents one granted channel at a time on a valid/ready output.
// RR_MODE=0: highest eligible index wins. RR_MODE=1: round-robin, searching
// downward from a pointer that moves just below each granted channel.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   irq : priority_irq_encoder_if.slave (req, mask, grant handshake)
// ----------------------------------------------------------------------------
module priority_irq_encoder #(
   parameter int N       = 16,
   parameter int RR_MODE = 0
) (
   input logic                    clk,
   input logic                    rst,
   priority_irq_encoder_if.slave  irq
);
   localparam int W = $clog2(N);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t       state_q;
   logic [N-1:0] req_q;
   logic [N-1:0] pend_q;
   logic [N-1:0] mask_q;
   logic [W-1:0] ptr_q;
   logic [W-1:0] index_q;

   logic [N-1:0] elig;
   logic [N-1:0] event_v;
   logic [N-1:0] clr;
   logic [N-1:0] pend_d;
   logic [W-1:0] ptr_d;
   logic [W-1:0] start;
   logic [W-1:0] sel;
   logic [W-1:0] cand;
   logic         load;
   logic         grant;
   int           idx;

   assign elig    = pend_q & mask_q;
   assign event_v = irq.req & ~req_q;
   assign load    = (state_q == IDLE) | irq.out_ready;
   assign grant   = load & (|elig);

   // Fixed priority is the round-robin search with the pointer pinned at N-1.
   assign start = (RR_MODE != 0) ? ptr_q : W'(N - 1);

   // Walk from the farthest candidate towards start so the last hit, the one
   // closest to start going downward with wrap, is the winner.
   always_comb begin
      sel  = '0;
      idx  = 0;
      cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(start) - k;
         if (idx < 0) idx = idx + N;
         cand = W'(idx);
         if (elig[cand]) sel = cand;
      end
   end

   // A new event on the granted channel wins over the grant's clear.
   always_comb begin
      clr = '0;
      if (grant) clr[sel] = 1'b1;
      pend_d = (pend_q & ~clr) | event_v;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant) ptr_d = (sel == '0) ? W'(N - 1) : sel - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         pend_q  <= '0;
         mask_q  <= '1;
         ptr_q   <= W'(N - 1);
         index_q <= '0;
      end else begin
         req_q  <= irq.req;
         pend_q <= pend_d;
         ptr_q  <= ptr_d;
         if (irq.mask_we) mask_q <= irq.mask_wdata;
         case (state_q)
            IDLE: begin
               if (grant) begin
                  state_q <= PRESENT;
                  index_q <= sel;
               end
            end
            PRESENT: begin
               // Without out_ready the presented grant is frozen.
               if (irq.out_ready) begin
                  if (grant) index_q <= sel;
                  else       state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign irq.out_valid   = (state_q == PRESENT);
   assign irq.out_index   = index_q;
   assign irq.any_pending = |elig;
   assign irq.mask_q      = mask_q;
endmodule

// File: tb/tb_priority_irq_encoder.sv
module tb_priority_irq_encoder;
   localparam int N = 8;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   exp_q[$];

   priority_irq_encoder_if #(.N(N)) if0 ();
   priority_irq_encoder_if #(.N(N)) if1 ();

   priority_irq_encoder #(.N(N), .RR_MODE(0)) u_fix (.clk(clk), .rst(rst), .irq(if0));
   priority_irq_encoder #(.N(N), .RR_MODE(1)) u_rr  (.clk(clk), .rst(rst), .irq(if1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      if0.req = '0; if0.mask_we = 1'b0; if0.mask_wdata = '0; if0.out_ready = 1'b0;
      if1.req = '0; if1.mask_we = 1'b0; if1.mask_wdata = '0; if1.out_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      if0.req = '0; if0.mask_we = 1'b0; if0.mask_wdata = '0; if0.out_ready = 1'b0;
      if1.req = '0; if1.mask_we = 1'b0; if1.mask_wdata = '0; if1.out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({if0.out_valid, if0.out_index, if0.any_pending, if0.mask_q} !== {1'b0, 3'd0, 1'b0, 8'hFF}) begin
         failures++;
         $display("FAIL reset_fix got v=%b i=%0d a=%b m=%h exp v=0 i=0 a=0 m=ff",
                  if0.out_valid, if0.out_index, if0.any_pending, if0.mask_q);
      end
      checks++;
      if ({if1.out_valid, if1.out_index, if1.any_pending, if1.mask_q} !== {1'b0, 3'd0, 1'b0, 8'hFF}) begin
         failures++;
         $display("FAIL reset_rr got v=%b i=%0d a=%b m=%h exp v=0 i=0 a=0 m=ff",
                  if1.out_valid, if1.out_index, if1.any_pending, if1.mask_q);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({if0.out_valid, if0.any_pending, if0.mask_q} !== {1'b0, 1'b0, 8'hFF}) begin
         failures++;
         $display("FAIL reset_release got v=%b a=%b m=%h exp v=0 a=0 m=ff",
                  if0.out_valid, if0.any_pending, if0.mask_q);
      end
   endtask

   // Two simultaneous events, fixed priority, consumer always ready.
   task automatic test_fixed_pair();
      int e;
      int h0 = -1;
      int h1 = -1;
      exp_q = {};
      exp_q.push_back(5);
      exp_q.push_back(2);
      @(negedge clk);
      if0.out_ready = 1'b1;
      if0.req = 8'b0010_0100;
      for (int c = 0; c < 10; c++) begin
         if (c == 1) if0.req = '0;
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL fixed_extra got=%0d exp=none", if0.out_index);
            end else begin
               e = exp_q.pop_front();
               if (if0.out_index !== W'(e)) begin
                  failures++;
                  $display("FAIL fixed_order got=%0d exp=%0d", if0.out_index, e);
               end
            end
            if (h0 < 0) h0 = c; else if (h1 < 0) h1 = c;
         end
         @(negedge clk);
      end
      checks++;
      if (h0 != 2 || h1 != 3) begin
         failures++;
         $display("FAIL fixed_timing got=%0d,%0d exp=2,3", h0, h1);
      end
      checks++;
      if (exp_q.size() != 0 || if0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL fixed_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), if0.out_valid);
      end
      idle();
   endtask

   // Presented grant must hold while not ready, despite new events and mask writes.
   task automatic test_hold();
      int e;
      exp_q = {};
      exp_q.push_back(3);
      exp_q.push_back(7);
      exp_q.push_back(5);
      @(negedge clk);
      if0.out_ready = 1'b0;
      if0.req = 8'h08;
      @(negedge clk);
      if0.req = 8'h88;
      checks++;
      if (if0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_early got v=%b exp v=0", if0.out_valid);
      end
      @(negedge clk);
      checks++;
      if ({if0.out_valid, if0.out_index, if0.any_pending} !== {1'b1, 3'd3, 1'b1}) begin
         failures++;
         $display("FAIL hold_first got v=%b i=%0d a=%b exp v=1 i=3 a=1",
                  if0.out_valid, if0.out_index, if0.any_pending);
      end
      if0.mask_we = 1'b1;
      if0.mask_wdata = 8'hF7;
      if0.req = 8'hA8;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if0.mask_we = 1'b0;
         checks++;
         if ({if0.out_valid, if0.out_index, if0.mask_q} !== {1'b1, 3'd3, 8'hF7}) begin
            failures++;
            $display("FAIL hold_stable got v=%b i=%0d m=%h exp v=1 i=3 m=f7",
                     if0.out_valid, if0.out_index, if0.mask_q);
         end
      end
      @(negedge clk);
      if0.out_ready = 1'b1;
      if0.mask_we = 1'b1;
      if0.mask_wdata = 8'hFF;
      for (int c = 0; c < 8; c++) begin
         if (c == 1) if0.mask_we = 1'b0;
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL hold_extra got=%0d exp=none", if0.out_index);
            end else begin
               e = exp_q.pop_front();
               if (if0.out_index !== W'(e)) begin
                  failures++;
                  $display("FAIL hold_order got=%0d exp=%0d", if0.out_index, e);
               end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || if0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL hold_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), if0.out_valid);
      end
      idle();
   endtask

   // Round robin over channels 7, 6, 1 with each granted channel re-raised.
   task automatic test_rr();
      int e;
      int ng = 0;
      int raise_ch = -1;
      logic [N-1:0] rq;
      exp_q = {7, 6, 1, 7, 6, 1};
      @(negedge clk);
      if1.out_ready = 1'b1;
      rq = 8'b1100_0010;
      for (int c = 0; c < 14; c++) begin
         if (raise_ch >= 0) begin
            rq[raise_ch] = 1'b1;
            raise_ch = -1;
         end
         if (if1.out_valid && if1.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rr_extra got=%0d exp=none", if1.out_index);
            end else begin
               e = exp_q.pop_front();
               if (if1.out_index !== W'(e)) begin
                  failures++;
                  $display("FAIL rr_order got=%0d exp=%0d", if1.out_index, e);
               end
            end
            ng++;
            rq[if1.out_index] = 1'b0;
            if (ng <= 3) raise_ch = int'(if1.out_index);
         end
         if1.req = rq;
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || if1.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rr_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), if1.out_valid);
      end
      idle();
   endtask

   // Fully masked event stays invisible, then is granted once unmasked.
   task automatic test_mask();
      int e;
      exp_q = {};
      exp_q.push_back(4);
      @(negedge clk);
      if0.out_ready = 1'b1;
      if0.mask_we = 1'b1;
      if0.mask_wdata = 8'h00;
      @(negedge clk);
      if0.mask_we = 1'b0;
      if0.req = 8'h10;
      checks++;
      if (if0.mask_q !== 8'h00) begin
         failures++;
         $display("FAIL mask_load got=%h exp=00", if0.mask_q);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if0.req = '0;
         checks++;
         if ({if0.out_valid, if0.any_pending} !== 2'b00) begin
            failures++;
            $display("FAIL mask_block got v=%b a=%b exp v=0 a=0", if0.out_valid, if0.any_pending);
         end
      end
      if0.mask_we = 1'b1;
      if0.mask_wdata = 8'hFF;
      @(negedge clk);
      if0.mask_we = 1'b0;
      checks++;
      if ({if0.out_valid, if0.any_pending, if0.mask_q} !== {1'b0, 1'b1, 8'hFF}) begin
         failures++;
         $display("FAIL mask_unmask got v=%b a=%b m=%h exp v=0 a=1 m=ff",
                  if0.out_valid, if0.any_pending, if0.mask_q);
      end
      @(negedge clk);
      checks++;
      if (!(if0.out_valid && if0.out_ready)) begin
         failures++;
         $display("FAIL mask_grant got v=%b exp v=1", if0.out_valid);
      end else begin
         e = exp_q.pop_front();
         if (if0.out_index !== W'(e)) begin
            failures++;
            $display("FAIL mask_grant got=%0d exp=%0d", if0.out_index, e);
         end
      end
      @(negedge clk);
      checks++;
      if (if0.out_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL mask_drain got v=%b left=%0d exp v=0 left=0", if0.out_valid, exp_q.size());
      end
      idle();
   endtask

   // New event on ch2 at the very edge that grants and clears ch2.
   task automatic test_set_wins();
      int e;
      exp_q = {5, 2, 2};
      @(negedge clk);
      if0.out_ready = 1'b0;
      if0.req = 8'h20;
      @(negedge clk);
      if0.req = 8'h24;
      @(negedge clk);
      if0.req = 8'h20;
      @(negedge clk);
      if0.req = 8'h24;
      if0.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL setwin_extra got=%0d exp=none", if0.out_index);
            end else begin
               e = exp_q.pop_front();
               if (if0.out_index !== W'(e)) begin
                  failures++;
                  $display("FAIL setwin_order got=%0d exp=%0d", if0.out_index, e);
               end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || if0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL setwin_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), if0.out_valid);
      end
      idle();
   endtask

   // Reset in the middle of a stalled handshake with three events still pending.
   task automatic test_reset_mid();
      int grants = 0;
      @(negedge clk);
      if0.out_ready = 1'b0;
      if0.mask_we = 1'b1;
      if0.mask_wdata = 8'hFB;
      @(negedge clk);
      if0.mask_we = 1'b0;
      if0.req = 8'h5A;
      @(negedge clk);
      if0.req = '0;
      @(negedge clk);
      checks++;
      if ({if0.out_valid, if0.out_index, if0.any_pending} !== {1'b1, 3'd6, 1'b1}) begin
         failures++;
         $display("FAIL rstmid_pre got v=%b i=%0d a=%b exp v=1 i=6 a=1",
                  if0.out_valid, if0.out_index, if0.any_pending);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({if0.out_valid, if0.out_index, if0.any_pending, if0.mask_q} !== {1'b0, 3'd0, 1'b0, 8'hFF}) begin
         failures++;
         $display("FAIL rstmid_async got v=%b i=%0d a=%b m=%h exp v=0 i=0 a=0 m=ff",
                  if0.out_valid, if0.out_index, if0.any_pending, if0.mask_q);
      end
      if0.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (if0.out_valid || if0.any_pending) grants++;
      end
      checks++;
      if (grants != 0) begin
         failures++;
         $display("FAIL rstmid_after got active_cycles=%0d exp=0", grants);
      end
      idle();
   endtask

   // A request held high across reset release counts as exactly one event.
   task automatic test_req_held();
      int e;
      exp_q = {};
      exp_q.push_back(0);
      @(negedge clk);
      rst = 1'b1;
      if0.req = 8'h01;
      if0.out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (if0.out_valid && if0.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL held_extra got=%0d exp=none", if0.out_index);
            end else begin
               e = exp_q.pop_front();
               if (if0.out_index !== W'(e)) begin
                  failures++;
                  $display("FAIL held_order got=%0d exp=%0d", if0.out_index, e);
               end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (exp_q.size() != 0 || if0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL held_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), if0.out_valid);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_fixed_pair();
      test_hold();
      test_rr();
      test_mask();
      test_set_wins();
      test_reset_mid();
      test_req_held();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
